// File: rtl/ariane_pkg.sv
// Functional-unit payload, PAU opcodes and PAU arbiter constants.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS   = 3;
  localparam int unsigned PAU_ARB_TIMEOUT = 16;

  typedef enum logic [3:0] {
    PADD, PSUB, PMUL, PDIV, PSQRT,
    QCLR, QMADD, QMSUB, QNEG, QROUND
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    riscv::xlen_t             operand_a;
    riscv::xlen_t             operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef enum logic [1:0] {
    PAU_IDLE, PAU_ISSUE, PAU_WAIT, PAU_RESP
  } pau_state_e;

  // Any op that touches the shared quire accumulator.
  function automatic logic is_quire_op(fu_op op);
    return op inside {QCLR, QMADD, QMSUB, QNEG, QROUND};
  endfunction

  // Quire ops that claim ownership of the accumulator.
  function automatic logic is_quire_acq(fu_op op);
    return op inside {QCLR, QMADD, QMSUB, QNEG};
  endfunction
endpackage

// File: rtl/riscv_pkg.sv
// Base RISC-V machine-word type shared by the execution units.
package riscv;
  localparam int unsigned XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/pau_rr_arb.sv
// Two-input round-robin grant: the pointed-to requester wins when both are eligible.
module pau_rr_arb (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = '0;
    if (eligible[ptr])       gnt[ptr]  = 1'b1;
    else if (eligible[~ptr]) gnt[~ptr] = 1'b1;
  end
endmodule

// File: rtl/pau_arbiter.sv
// Shares one PAU between two requesters, one op in flight, with response timeout.
// Optional quire ownership lock enabled by defining PAU_QUIRE_LOCK_EN.
module pau_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned TIMEOUT = PAU_ARB_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    req_valid_i,
  output logic [1:0]                    req_ready_o,
  input  fu_data_t [1:0]                req_data_i,
  output logic [1:0]                    rsp_valid_o,
  output logic [1:0][TRANS_ID_BITS-1:0] rsp_trans_id_o,
  output riscv::xlen_t [1:0]            rsp_result_o,
  output logic [1:0]                    rsp_err_o,
  output fu_data_t                      pau_data_o,
  output logic                          pau_valid_o,
  input  logic                          pau_valid_i,
  input  logic [TRANS_ID_BITS-1:0]      pau_trans_id_i,
  input  riscv::xlen_t                  pau_result_i
);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  pau_state_e       state_q;
  logic             ptr_q;
  logic             hold_idx_q;
  fu_data_t         hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       eligible, gnt, accept;
  logic             acc_idx, match, timeout;

`ifdef PAU_QUIRE_LOCK_EN
  logic lock_q, owner_q;

  // Quire ops from the non-owner are held off while the lock is taken.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      eligible[r] = req_valid_i[r] &
                    ~(lock_q && (owner_q != 1'(r)) && is_quire_op(req_data_i[r].operation));
    end
  end
`else
  assign eligible = req_valid_i;
`endif

  pau_rr_arb u_rr_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .gnt      (gnt)
  );

  // Ready is gated by reset so every output is quiet while rst_ni is low.
  assign req_ready_o = (rst_ni && state_q == PAU_IDLE) ? gnt : 2'b00;
  assign accept      = req_valid_i & req_ready_o;
  assign acc_idx     = accept[1];
  assign match       = pau_valid_i && (pau_trans_id_i == hold_q.trans_id);
  assign timeout     = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign pau_valid_o = (state_q == PAU_ISSUE);
  assign pau_data_o  = (state_q == PAU_ISSUE) ? hold_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= PAU_IDLE;
      ptr_q          <= 1'b0;
      hold_idx_q     <= 1'b0;
      hold_q         <= '0;
      cnt_q          <= '0;
      rsp_valid_o    <= '0;
      rsp_trans_id_o <= '0;
      rsp_result_o   <= '0;
      rsp_err_o      <= '0;
`ifdef PAU_QUIRE_LOCK_EN
      lock_q         <= 1'b0;
      owner_q        <= 1'b0;
`endif
    end else begin
      rsp_valid_o    <= '0;
      rsp_trans_id_o <= '0;
      rsp_result_o   <= '0;
      rsp_err_o      <= '0;
      case (state_q)
        PAU_IDLE: begin
          if (|accept) begin
            hold_q     <= req_data_i[acc_idx];
            hold_idx_q <= acc_idx;
            ptr_q      <= ~acc_idx;
            state_q    <= PAU_ISSUE;
`ifdef PAU_QUIRE_LOCK_EN
            if (is_quire_acq(req_data_i[acc_idx].operation)) begin
              lock_q  <= 1'b1;
              owner_q <= acc_idx;
            end else if (req_data_i[acc_idx].operation == QROUND && lock_q &&
                         owner_q == acc_idx) begin
              lock_q <= 1'b0;
            end
`endif
          end
        end
        PAU_ISSUE: begin
          cnt_q   <= '0;
          state_q <= PAU_WAIT;
        end
        // A matching result wins over a timeout landing in the same cycle.
        PAU_WAIT: begin
          if (match || timeout) begin
            state_q                     <= PAU_RESP;
            rsp_valid_o[hold_idx_q]     <= 1'b1;
            rsp_trans_id_o[hold_idx_q]  <= hold_q.trans_id;
            rsp_result_o[hold_idx_q]    <= match ? pau_result_i : '0;
            rsp_err_o[hold_idx_q]       <= ~match;
`ifdef PAU_QUIRE_LOCK_EN
            if (!match) lock_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PAU_RESP: state_q <= PAU_IDLE;
        default:  state_q <= PAU_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pau_arbiter.sv
// Directed scoreboard bench for pau_arbiter; quire-lock steps run when PAU_QUIRE_LOCK_EN is defined.
module tb_pau_arbiter;
  import ariane_pkg::*;

  typedef struct packed {
    logic                     idx;
    logic [TRANS_ID_BITS-1:0] id;
    logic [63:0]              res;
    logic                     err;
  } exp_t;

  logic                          clk;
  logic                          rst_n;
  logic [1:0]                    req_valid;
  logic [1:0]                    req_ready;
  fu_data_t [1:0]                req_data;
  logic [1:0]                    rsp_valid;
  logic [1:0][TRANS_ID_BITS-1:0] rsp_id;
  riscv::xlen_t [1:0]            rsp_res;
  logic [1:0]                    rsp_err;
  fu_data_t                      pau_data;
  logic                          pau_valid;
  logic                          pau_valid_i;
  logic [TRANS_ID_BITS-1:0]      pau_id;
  riscv::xlen_t                  pau_res;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  pau_arbiter #(.TIMEOUT(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_data_i     (req_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_trans_id_o (rsp_id),
    .rsp_result_o   (rsp_res),
    .rsp_err_o      (rsp_err),
    .pau_data_o     (pau_data),
    .pau_valid_o    (pau_valid),
    .pau_valid_i    (pau_valid_i),
    .pau_trans_id_i (pau_id),
    .pau_result_i   (pau_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic fu_data_t mk(input fu_op op, input logic [TRANS_ID_BITS-1:0] id);
    fu_data_t d;
    d.operation = op;
    d.operand_a = 64'h1234_5678_9abc_def0 ^ 64'(id);
    d.operand_b = ~d.operand_a;
    d.trans_id  = id;
    return d;
  endfunction

  // Pops the oldest expected response and compares every response lane.
  task automatic check_rsp();
    exp_t       e;
    logic [1:0] v;
    e = sb.pop_front();
    v = 2'b00;
    v[e.idx] = 1'b1;
    chk("rsp_valid", 256'(rsp_valid), 256'(v));
    chk("rsp_id", 256'(rsp_id[e.idx]), 256'(e.id));
    chk("rsp_result", 256'(rsp_res[e.idx]), 256'(e.res));
    chk("rsp_err", 256'(rsp_err[e.idx]), 256'(e.err));
    chk("rsp_other_lane", 256'({rsp_id[~e.idx], rsp_res[~e.idx], rsp_err[~e.idx]}), 256'(0));
  endtask

  // Full op starting at an IDLE negedge with the PAU answering one cycle after issue.
  task automatic run_op(input int r, input fu_data_t d, input logic [63:0] res,
                        input logic [1:0] exp_ready);
    req_data[r]  = d;
    req_valid[r] = 1'b1;
    #1;
    chk("ready_idle", 256'(req_ready), 256'(exp_ready));
    sb.push_back('{idx: 1'(r), id: d.trans_id, res: res, err: 1'b0});
    @(negedge clk);
    req_valid[r] = 1'b0;
    chk("issue_valid", 256'(pau_valid), 256'(1'b1));
    chk("issue_data", 256'(pau_data), 256'(d));
    @(negedge clk);
    pau_valid_i = 1'b1;
    pau_id      = d.trans_id;
    pau_res     = res;
    @(negedge clk);
    pau_valid_i = 1'b0;
    #1;
    chk("ready_resp", 256'(req_ready), 256'(2'b00));
    check_rsp();
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      pau_valid_i = 1'b0;
      n++;
      if (rsp_valid != 2'b00) break;
    end
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    req_valid   = 2'b11;
    req_data    = '0;
    pau_valid_i = 1'b0;
    pau_id      = '0;
    pau_res     = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 256'(req_ready), 256'(0));
    chk("reset_pau", 256'({pau_valid, pau_data}), 256'(0));
    chk("reset_rsp", 256'({rsp_valid, rsp_id, rsp_res, rsp_err}), 256'(0));
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);

    // Both post PADD at once: r0 first, r1 right after r0's RESP.
    req_data[1]  = mk(PADD, 3'd5);
    req_valid[1] = 1'b1;
    run_op(0, mk(PADD, 3'd3), 64'h0000_0000_0000_aaaa, 2'b01);
    run_op(1, mk(PADD, 3'd5), 64'h0000_0000_0000_bbbb, 2'b10);

    // PMUL with one-cycle PAU latency: response exactly 3 cycles after acceptance.
    req_data[0]  = mk(PMUL, 3'd2);
    req_valid[0] = 1'b1;
    #1;
    chk("pmul_ready", 256'(req_ready), 256'(2'b01));
    sb.push_back('{idx: 1'b0, id: 3'd2, res: 64'hdead_beef_0000_0002, err: 1'b0});
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("pmul_issue", 256'(pau_valid), 256'(1'b1));
    @(negedge clk);
    pau_valid_i = 1'b1;
    pau_id      = 3'd2;
    pau_res     = 64'hdead_beef_0000_0002;
    chk("pmul_no_early_rsp", 256'(rsp_valid), 256'(0));
    @(negedge clk);
    pau_valid_i = 1'b0;
    check_rsp();
    @(negedge clk);

    // Wrong id ignored; correct id two cycles later supplies the result.
    req_data[1]  = mk(PDIV, 3'd6);
    req_valid[1] = 1'b1;
    #1;
    chk("mismatch_ready", 256'(req_ready), 256'(2'b10));
    sb.push_back('{idx: 1'b1, id: 3'd6, res: 64'h0000_0000_0000_600d, err: 1'b0});
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    pau_valid_i = 1'b1;
    pau_id      = 3'd1;
    pau_res     = 64'h0000_0000_0000_0bad;
    @(negedge clk);
    pau_valid_i = 1'b0;
    chk("mismatch_ignored", 256'(rsp_valid), 256'(0));
    @(negedge clk);
    pau_valid_i = 1'b1;
    pau_id      = 3'd6;
    pau_res     = 64'h0000_0000_0000_600d;
    @(negedge clk);
    pau_valid_i = 1'b0;
    check_rsp();
    @(negedge clk);

    // Silent PAU: error response 17 cycles after issue; a result during ISSUE is ignored.
    req_data[0]  = mk(PSUB, 3'd4);
    req_valid[0] = 1'b1;
    #1;
    sb.push_back('{idx: 1'b0, id: 3'd4, res: 64'h0, err: 1'b1});
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("timeout_issue", 256'(pau_valid), 256'(1'b1));
    pau_valid_i = 1'b1;
    pau_id      = 3'd4;
    pau_res     = 64'h0000_0000_0000_1111;
    wait_rsp(40, n);
    chk("timeout_latency", 256'(n), 256'(17));
    check_rsp();
    @(negedge clk);

    // Match on the final WAIT cycle beats the timeout.
    req_data[1]  = mk(PADD, 3'd7);
    req_valid[1] = 1'b1;
    #1;
    chk("edge_ready", 256'(req_ready), 256'(2'b10));
    sb.push_back('{idx: 1'b1, id: 3'd7, res: 64'h0000_0000_0000_7777, err: 1'b0});
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (16) @(negedge clk);
    chk("edge_no_early_rsp", 256'(rsp_valid), 256'(0));
    pau_valid_i = 1'b1;
    pau_id      = 3'd7;
    pau_res     = 64'h0000_0000_0000_7777;
    @(negedge clk);
    pau_valid_i = 1'b0;
    check_rsp();
    @(negedge clk);

    // Request withdrawn before the clock edge leaves no trace.
    req_data[0]  = mk(PADD, 3'd2);
    req_valid[0] = 1'b1;
    #1;
    chk("drop_ready", 256'(req_ready), 256'(2'b01));
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("drop_no_issue", 256'(pau_valid), 256'(0));

    // Reset during WAIT: op discarded, late result ignored, pointer back at r0.
    req_data[0]  = mk(PADD, 3'd1);
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_data[1]  = mk(PADD, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 256'({req_ready, pau_valid, rsp_valid}), 256'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    pau_valid_i = 1'b1;
    pau_id      = 3'd1;
    pau_res     = 64'h0000_0000_0000_1a7e;
    @(negedge clk);
    pau_valid_i = 1'b0;
    chk("rst_late_rsp0", 256'(rsp_valid), 256'(0));
    @(negedge clk);
    chk("rst_late_rsp1", 256'(rsp_valid), 256'(0));
    req_valid = 2'b11;
    #1;
    chk("rst_ptr_idle", 256'(req_ready), 256'(2'b01));
    chk("rst_no_issue", 256'(pau_valid), 256'(0));
    req_valid = 2'b00;
    @(negedge clk);

`ifdef PAU_QUIRE_LOCK_EN
    // r0 owns the quire: r1's QMADD stalls, its PADD passes, QMADD follows r0's QROUND.
    req_data[1]  = mk(QMADD, 3'd2);
    req_valid[1] = 1'b1;
    run_op(0, mk(QCLR, 3'd1), 64'h0000_0000_0000_0011, 2'b01);
    #1;
    chk("quire_stall", 256'(req_ready), 256'(2'b00));
    run_op(1, mk(PADD, 3'd3), 64'h0000_0000_0000_0033, 2'b10);
    req_data[1]  = mk(QMADD, 3'd2);
    req_valid[1] = 1'b1;
    run_op(0, mk(QROUND, 3'd4), 64'h0000_0000_0000_0044, 2'b01);
    run_op(1, mk(QMADD, 3'd2), 64'h0000_0000_0000_0022, 2'b10);
`endif

    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
